// File: rtl/ps2_pkg.sv
// Shared constants, event layout and FSM encoding for the PS/2 set-2 key event decoder.
package ps2_pkg;

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_E1 = 8'hE1;
  localparam logic [7:0] B_FA = 8'hFA;
  localparam logic [7:0] B_AA = 8'hAA;
  localparam logic [7:0] B_EE = 8'hEE;
  localparam logic [7:0] B_FE = 8'hFE;
  localparam logic [7:0] B_FC = 8'hFC;
  localparam logic [7:0] B_00 = 8'h00;
  localparam logic [7:0] B_FF = 8'hFF;

  localparam logic [7:0] PAUSE_CODE = 8'h77;
  // Pause key sends E1 plus 7 more bytes; counter index of the last one.
  localparam logic [2:0] PAUSE_LAST = 3'd6;

  localparam int EV_EXT = 9;
  localparam int EV_BRK = 8;
  localparam int EV_W   = 10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  // Bit layout matches EV_EXT/EV_BRK/code[7:0].
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == B_E0) || (b == B_F0) || (b == B_E1);
  endfunction

  // Keyboard replies (ACK, BAT ok, echo, resend) carry no key information.
  function automatic logic is_status(input logic [7:0] b);
    return (b == B_FA) || (b == B_AA) || (b == B_EE) || (b == B_FE);
  endfunction

  // BAT failure and buffer-overrun/error codes.
  function automatic logic is_fault(input logic [7:0] b);
    return (b == B_FC) || (b == B_00) || (b == B_FF);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata always shows the head entry.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        push_en, pop_en;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  // Pop on empty is ignored; push on full only lands if a pop frees a slot.
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign rdata   = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Folds set-2 scan-code prefix sequences into {ext, brk, code} events and queues them.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET_N,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          rx_err,
  output logic [EV_W-1:0]               ev_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          kbd_fault,
  input  logic                          clr_status
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state, state_nxt;
  logic [2:0]    pcnt, pcnt_nxt;
  logic [TW-1:0] tcnt;
  logic          push, fault_set, ovf_set;
  ev_t           push_ev;
  logic          fifo_full, fifo_empty;

  // Next-state, event generation and fault detection for each received byte.
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    push      = 1'b0;
    push_ev   = '0;
    fault_set = 1'b0;
    if (rx_err) begin
      fault_set = 1'b1;
      state_nxt = S_IDLE;
      pcnt_nxt  = '0;
    end else if (rx_valid) begin
      case (state)
        S_IDLE: begin
          if (rx_data == B_E0)       state_nxt = S_EXT;
          else if (rx_data == B_F0)  state_nxt = S_BRK;
          else if (rx_data == B_E1) begin
            state_nxt = S_PAUSE;
            pcnt_nxt  = '0;
          end
          else if (is_fault(rx_data)) fault_set = 1'b1;
          else if (!is_status(rx_data)) begin
            push    = 1'b1;
            push_ev = '{ext: 1'b0, brk: 1'b0, code: rx_data};
          end
        end
        S_EXT: begin
          if (rx_data == B_F0) state_nxt = S_EXT_BRK;
          else if (rx_data != B_E0 && rx_data != B_E1) begin
            push      = 1'b1;
            push_ev   = '{ext: 1'b1, brk: 1'b0, code: rx_data};
            state_nxt = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          // A prefix here means a corrupted sequence: drop it entirely.
          if (!is_prefix(rx_data)) begin
            push    = 1'b1;
            push_ev = '{ext: (state == S_EXT_BRK), brk: 1'b1, code: rx_data};
          end
          state_nxt = S_IDLE;
        end
        S_PAUSE: begin
          if (pcnt == PAUSE_LAST) begin
            push      = 1'b1;
            push_ev   = '{ext: 1'b1, brk: 1'b0, code: PAUSE_CODE};
            state_nxt = S_IDLE;
            pcnt_nxt  = '0;
          end else begin
            pcnt_nxt = pcnt + 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE && tcnt == TO_LAST) begin
      state_nxt = S_IDLE;
      pcnt_nxt  = '0;
    end
  end

  // State and pause-count registers.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state <= S_IDLE;
      pcnt  <= '0;
    end else begin
      state <= state_nxt;
      pcnt  <= pcnt_nxt;
    end
  end

  // Idle-cycle counter for abandoning a stalled prefix sequence.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N)
      tcnt <= '0;
    else if (rx_valid || rx_err || state == S_IDLE || tcnt == TO_LAST)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end

  // A full FIFO is never empty, so a push is dropped exactly when ev_ready is low.
  assign ovf_set = push & fifo_full & ~ev_ready;

  // Sticky status flags; a new set event beats a same-cycle clear.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      overflow  <= 1'b0;
      kbd_fault <= 1'b0;
    end else begin
      overflow  <= ovf_set   | (overflow  & ~clr_status);
      kbd_fault <= fault_set | (kbd_fault & ~clr_status);
    end
  end

  ps2_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .push  (push),
    .wdata (push_ev),
    .pop   (ev_ready),
    .rdata (ev_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign ev_valid = ~fifo_empty;

endmodule
